// File: rtl/ctrl_pipe_gen.sv
// ctrl_pipe_gen -- parametrised accumulator CPU core with a req/ack memory port.
//
// Ports:
//   clock, reset      : rising-edge clock; asynchronous active-high reset
//   mem_addr/mem_we   : transaction address and direction (1 = store)
//   mem_wdata         : store data (acc), valid while mem_req && mem_we
//   mem_rdata         : load/fetch data, instruction is mem_rdata[7:0]
//   mem_req/mem_ack   : a transaction completes on the edge where both are high
//   acc_out           : current accumulator
//   halted, fault     : high while in HALT / FAULT (left only through reset)
//
// Memory-side outputs are registered, so reset clears them at once and the
// first fetch request is raised on the first edge after reset is released.
// A request is always dropped for at least one cycle after it completes.
module ctrl_pipe_gen #(
    parameter int               WIDTH    = 8,
    parameter int               ADDR_W   = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [WIDTH-1:0]  acc_out,
    output logic              halted,
    output logic              fault
);
    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WMOD  = WIDTH'(WIDTH);

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_MUL, S_HALT, S_FAULT} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  acc, acc_n;
    logic [WIDTH-1:0]  regs   [0:7];
    logic [WIDTH-1:0]  regs_n [0:7];
    logic [7:0]        ins, ins_n;
    logic [WIDTH-1:0]  mcand, mcand_n, mplier, mplier_n, part, part_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              req_n, we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [WIDTH-1:0]  wdata_n;

    // instruction fields and operands
    logic [3:0]        op;
    logic              x;
    logic [2:0]        rs;
    logic [WIDTH-1:0]  rval, off, shamt;

    assign op      = ins[7:4];
    assign x       = ins[3];
    assign rs      = ins[2:0];
    assign rval    = regs[rs];
    assign off     = {{(WIDTH-4){ins[3]}}, ins[3:0]};
    assign shamt   = rval % WMOD;
    assign acc_out = acc;
    assign halted  = (state == S_HALT);
    assign fault   = (state == S_FAULT);

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        regs_n   = regs;
        ins_n    = ins;
        mcand_n  = mcand;
        mplier_n = mplier;
        part_n   = part;
        cnt_n    = cnt;
        req_n    = mem_req;
        we_n     = mem_we;
        addr_n   = mem_addr;
        wdata_n  = mem_wdata;
        case (state)
            S_FETCH: begin
                if (mem_req && mem_ack) begin
                    ins_n     = mem_rdata[7:0];
                    regs_n[7] = regs[7] + 1'b1;
                    req_n     = 1'b0;
                    state_n   = S_EXEC;
                end else if (!mem_req) begin
                    // entered from reset or after a data transaction
                    req_n  = 1'b1;
                    we_n   = 1'b0;
                    addr_n = regs[7][ADDR_W-1:0];
                end
            end
            S_EXEC: begin
                state_n = S_FETCH;
                case (op)
                    4'b0000: acc_n = x ? acc - rval : acc + rval;
                    4'b0001: acc_n = x ? acc | rval : acc & rval;
                    4'b0010: acc_n = x ? acc >> shamt : acc << shamt;
                    4'b0011: acc_n = x ? acc ^ rval : ~acc;
                    4'b1100: acc_n = {acc[WIDTH-1:4], ins[3:0]};
                    4'b1101: begin
                        if (x) regs_n[rs] = acc;
                        else   acc_n      = rval;
                    end
                    4'b0100: regs_n[7] = regs[7] + off;
                    4'b0101: if (acc == '0)       regs_n[7] = regs[7] + off;
                    4'b0110: if (!acc[WIDTH-1])   regs_n[7] = regs[7] + off;
                    4'b1110: state_n = S_MEM;
                    4'b1000: begin
                        state_n  = S_MUL;
                        mcand_n  = acc;
                        mplier_n = rval;
                        part_n   = '0;
                        cnt_n    = '0;
                    end
                    4'b1111: ;
                    4'b1010: state_n = S_HALT;
                    default: state_n = S_FAULT;
                endcase
                // raise the next request here so plain instructions take 2 cycles;
                // regs_n[7] already reflects any jump or taken branch
                if (state_n == S_FETCH) begin
                    req_n  = 1'b1;
                    we_n   = 1'b0;
                    addr_n = regs_n[7][ADDR_W-1:0];
                end else if (state_n == S_MEM) begin
                    req_n   = 1'b1;
                    we_n    = x;
                    addr_n  = rval[ADDR_W-1:0];
                    wdata_n = acc;
                end
            end
            S_MEM: begin
                if (mem_req && mem_ack) begin
                    if (!mem_we) acc_n = mem_rdata;
                    req_n   = 1'b0;
                    we_n    = 1'b0;
                    state_n = S_FETCH;
                end
            end
            S_MUL: begin
                // one multiplier bit per cycle; acc only changes on the last step
                part_n   = part + (mplier[0] ? mcand : '0);
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt + 1'b1;
                if (cnt == LAST) begin
                    acc_n   = part_n;
                    state_n = S_FETCH;
                    req_n   = 1'b1;
                    we_n    = 1'b0;
                    addr_n  = regs[7][ADDR_W-1:0];
                end
            end
            default: ;  // HALT / FAULT absorb, req already low
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            acc       <= '0;
            ins       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            part      <= '0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int i = 0; i < 7; i++) regs[i] <= WIDTH'(i);
            regs[7]   <= RESET_PC;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            ins       <= ins_n;
            mcand     <= mcand_n;
            mplier    <= mplier_n;
            part      <= part_n;
            cnt       <= cnt_n;
            mem_req   <= req_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            regs      <= regs_n;
        end
    end
endmodule

// File: tb/tb_ctrl_pipe_gen.sv
// Bench for ctrl_pipe_gen: an 8-bit core on a wait-state memory and a 16-bit
// core on zero-wait memory. Expected memory transactions are queued per test
// and checked by a monitor as each one completes.
module tb_ctrl_pipe_gen;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic rst16 = 1'b0;
    always #5 clock = ~clock;

    // 8-bit core
    logic [7:0] addr8, wd8, rd8, acc8;
    logic       req8, we8, ack8, halted8, fault8;
    ctrl_pipe_gen #(.WIDTH(8), .ADDR_W(8), .RESET_PC(8'h00)) u8 (
        .clock(clock), .reset(reset), .mem_addr(addr8), .mem_wdata(wd8),
        .mem_rdata(rd8), .mem_req(req8), .mem_we(we8), .mem_ack(ack8),
        .acc_out(acc8), .halted(halted8), .fault(fault8));

    // 16-bit core, ack tied high
    logic [7:0]  addr16;
    logic [15:0] wd16, rd16, acc16;
    logic        req16, we16, halted16, fault16;
    logic [7:0]  mem16 [256];
    assign rd16 = {8'h00, mem16[addr16]};
    ctrl_pipe_gen #(.WIDTH(16), .ADDR_W(8), .RESET_PC(16'h0000)) u16 (
        .clock(clock), .reset(rst16), .mem_addr(addr16), .mem_wdata(wd16),
        .mem_rdata(rd16), .mem_req(req16), .mem_we(we16), .mem_ack(1'b1),
        .acc_out(acc16), .halted(halted16), .fault(fault16));

    // wait-state memory for the 8-bit core: program in mem8, stores overlay it
    logic [7:0]   mem8   [256];
    logic [7:0]   st_mem [256];
    logic [255:0] st_valid;
    logic         mem_clr = 1'b0;
    int           waits   = 0;
    logic [7:0]   wcnt;
    assign ack8 = req8 && (int'(wcnt) >= waits);
    assign rd8  = st_valid[addr8] ? st_mem[addr8] : mem8[addr8];
    always @(posedge clock) begin
        if (reset || !req8 || ack8) wcnt <= 8'd0;
        else                        wcnt <= wcnt + 8'd1;
        if (mem_clr) st_valid <= '0;
        else if (!reset && req8 && ack8 && we8) begin
            st_valid[addr8] <= 1'b1;
            st_mem[addr8]   <= wd8;
        end
    end

    typedef struct { logic [7:0] addr; logic we; logic [7:0] wdata; } txn_t;
    txn_t exp_q [$];
    int   tests = 0;
    int   fails = 0;

    task automatic push(input logic [7:0] a, input logic w, input logic [7:0] d);
        txn_t t;
        t.addr = a; t.we = w; t.wdata = d;
        exp_q.push_back(t);
    endtask

    task automatic push_fetches(input logic [7:0] a0, input int n);
        for (int i = 0; i < n; i++) push(a0 + 8'(i), 1'b0, 8'h00);
    endtask

    task automatic load_hlt();
        for (int i = 0; i < 256; i++) mem8[i] = 8'hA0;
    endtask

    task automatic hold_reset();
        @(negedge clock); #1;
        reset = 1'b1; mem_clr = 1'b1; exp_q.delete();
        @(negedge clock); #1;
        mem_clr = 1'b0;
    endtask

    task automatic drain(input int bound, output bit ok);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) begin
            @(negedge clock); #1;
        end
        ok = (exp_q.size() == 0);
        repeat (2) begin @(negedge clock); #1; end
    endtask

    // handshake monitor and scoreboard for the 8-bit core
    task automatic monitor();
        logic       p_req = 1'b0, p_done = 1'b0, p_we = 1'b0;
        logic [7:0] p_addr = 8'h00, p_wd = 8'h00;
        txn_t       e;
        forever begin
            @(negedge clock);
            if (reset) begin
                p_req = 1'b0; p_done = 1'b0;
            end else begin
                if (p_done) begin
                    tests++;
                    if (req8 !== 1'b0) begin
                        fails++; $display("FAIL req_gap: req=%b want 0 after completion", req8);
                    end
                end else if (p_req) begin
                    tests++;
                    if (req8 !== 1'b1 || addr8 !== p_addr || we8 !== p_we || (p_we && wd8 !== p_wd)) begin
                        fails++;
                        $display("FAIL req_hold: req=%b addr=%h we=%b wd=%h want 1 %h %b %h",
                                 req8, addr8, we8, wd8, p_addr, p_we, p_wd);
                    end
                end
                if (halted8 || fault8) begin
                    tests++;
                    if (req8 !== 1'b0) begin
                        fails++; $display("FAIL req_stopped: req=%b want 0 in halt/fault", req8);
                    end
                end
                if (req8 && ack8) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++; $display("FAIL txn_extra: addr=%h we=%b want none", addr8, we8);
                    end else begin
                        e = exp_q.pop_front();
                        if (addr8 !== e.addr || we8 !== e.we || (e.we && wd8 !== e.wdata)) begin
                            fails++;
                            $display("FAIL txn: addr=%h we=%b wd=%h want %h %b %h",
                                     addr8, we8, wd8, e.addr, e.we, e.wdata);
                        end
                    end
                end
                p_done = req8 && ack8;
                p_req  = req8;
                p_addr = addr8; p_we = we8; p_wd = wd8;
            end
        end
    endtask

    task automatic test_reset();
        load_hlt();
        waits = 1000;
        hold_reset();
        tests++;
        if ({req8, we8, halted8, fault8} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags: got %b want 0000", {req8, we8, halted8, fault8});
        end
        tests++;
        if (addr8 !== 8'h00 || wd8 !== 8'h00 || acc8 !== 8'h00) begin
            fails++; $display("FAIL reset_vals: addr=%h wd=%h acc=%h want 00", addr8, wd8, acc8);
        end
        reset = 1'b0;
        tests++;
        if (req8 !== 1'b0) begin
            fails++; $display("FAIL req_before_edge: got %b want 0", req8);
        end
        @(posedge clock); #1;
        tests++;
        if (req8 !== 1'b1 || addr8 !== 8'h00 || we8 !== 1'b0) begin
            fails++; $display("FAIL first_fetch: req=%b addr=%h we=%b want 1 00 0", req8, addr8, we8);
        end
    endtask

    task automatic test_zero_wait();
        bit ok, started;
        int cyc;
        hold_reset();
        load_hlt();
        mem8[0] = 8'hC5; mem8[1] = 8'h03; mem8[2] = 8'hD8; mem8[3] = 8'hA0;
        waits = 0;
        push_fetches(8'h00, 4);
        reset = 1'b0;
        started = 0; cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (started) cyc++;
            if (req8) started = 1;
            if (halted8) break;
        end
        #1;
        drain(20, ok);
        repeat (4) @(negedge clock);
        tests++;
        if (!ok) begin fails++; $display("FAIL zw_drain: %0d left want 0", exp_q.size()); end
        tests++;
        if (cyc != 8) begin fails++; $display("FAIL zw_cycles: got %0d want 8", cyc); end
        tests++;
        if (acc8 !== 8'h08 || halted8 !== 1'b1 || fault8 !== 1'b0) begin
            fails++; $display("FAIL zw_state: acc=%h h=%b f=%b want 08 1 0", acc8, halted8, fault8);
        end
        tests++;
        if (u8.regs[0] !== 8'h08) begin fails++; $display("FAIL zw_r0: got %h want 08", u8.regs[0]); end
    endtask

    task automatic test_mul();
        bit found, same;
        int low;
        for (int i = 0; i < 256; i++) mem16[i] = 8'hA0;
        mem16[0] = 8'hCF; mem16[1] = 8'h24; mem16[2] = 8'h86; mem16[3] = 8'hA0;
        rst16 = 1'b1;
        @(negedge clock); #1;
        rst16 = 1'b0;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (req16 && addr16 == 8'h02) begin found = 1; break; end
        end
        tests++;
        if (!found) begin fails++; $display("FAIL mul_fetch: never fetched addr 02"); end
        tests++;
        if (acc16 !== 16'h00F0) begin fails++; $display("FAIL lsl: got %h want 00f0", acc16); end
        low = 0; same = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (req16) break;
            low++;
            if (acc16 !== 16'h00F0) same = 0;
        end
        tests++;
        if (low != 17) begin fails++; $display("FAIL mul_cycles: got %0d want 17", low); end
        tests++;
        if (!same) begin fails++; $display("FAIL mul_hold: acc changed before completion"); end
        tests++;
        if (acc16 !== 16'h05A0 || addr16 !== 8'h03) begin
            fails++; $display("FAIL mul_result: acc=%h addr=%h want 05a0 03", acc16, addr16);
        end
        repeat (4) @(negedge clock);
        tests++;
        if (halted16 !== 1'b1) begin fails++; $display("FAIL mul_halt: got %b want 1", halted16); end
    endtask

    task automatic test_wait_ldst();
        bit ok;
        hold_reset();
        load_hlt();
        mem8[0] = 8'hC3; mem8[1] = 8'h24; mem8[2] = 8'hCC; mem8[3] = 8'hEA;
        mem8[4] = 8'h30; mem8[5] = 8'hE2; mem8[6] = 8'hA0;
        waits = 3;
        push_fetches(8'h00, 4);
        push(8'h02, 1'b1, 8'h3C);
        push_fetches(8'h04, 2);
        push(8'h02, 1'b0, 8'h00);
        push_fetches(8'h06, 1);
        reset = 1'b0;
        drain(300, ok);
        repeat (3) @(negedge clock);
        tests++;
        if (!ok) begin fails++; $display("FAIL ldst_drain: %0d left want 0", exp_q.size()); end
        tests++;
        if (acc8 !== 8'h3C || halted8 !== 1'b1) begin
            fails++; $display("FAIL ldst_acc: acc=%h h=%b want 3c 1", acc8, halted8);
        end
    endtask

    task automatic test_branch();
        bit ok;
        // BZ -2 at 0x05 with acc=0 loops back to 0x04
        hold_reset();
        load_hlt();
        for (int i = 0; i < 5; i++) mem8[i] = 8'hF0;
        mem8[5] = 8'h5E;
        waits = 3;
        push_fetches(8'h00, 6);
        push(8'h04, 1'b0, 8'h00); push(8'h05, 1'b0, 8'h00); push(8'h04, 1'b0, 8'h00);
        reset = 1'b0;
        drain(300, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL bz_taken: %0d left want 0", exp_q.size()); end
        // same with acc=1 falls through to 0x06
        hold_reset();
        load_hlt();
        mem8[0] = 8'hC1;
        for (int i = 1; i < 5; i++) mem8[i] = 8'hF0;
        mem8[5] = 8'h5E;
        waits = 0;
        push_fetches(8'h00, 7);
        reset = 1'b0;
        drain(100, ok);
        tests++;
        if (!ok || halted8 !== 1'b1) begin
            fails++; $display("FAIL bz_not_taken: left=%0d h=%b want 0 1", exp_q.size(), halted8);
        end
        // BNN with acc=0x80 falls through
        hold_reset();
        load_hlt();
        mem8[0] = 8'hC8; mem8[1] = 8'h24; mem8[2] = 8'h6E; mem8[3] = 8'hA0;
        push_fetches(8'h00, 4);
        reset = 1'b0;
        drain(100, ok);
        tests++;
        if (!ok || acc8 !== 8'h80 || halted8 !== 1'b1) begin
            fails++; $display("FAIL bnn: left=%0d acc=%h h=%b want 0 80 1", exp_q.size(), acc8, halted8);
        end
    endtask

    task automatic test_fault_reset();
        bit ok;
        hold_reset();
        load_hlt();
        mem8[0] = 8'h70;
        waits = 0;
        push_fetches(8'h00, 1);
        reset = 1'b0;
        drain(50, ok);
        repeat (5) @(negedge clock);
        tests++;
        if (!ok || fault8 !== 1'b1 || halted8 !== 1'b0) begin
            fails++; $display("FAIL fault: left=%0d f=%b h=%b want 0 1 0", exp_q.size(), fault8, halted8);
        end
        // reset while a fetch is outstanding
        hold_reset();
        load_hlt();
        mem8[0] = 8'hC5; mem8[1] = 8'hF0;
        waits = 3;
        push_fetches(8'h00, 1);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock); #1;
            if (acc8 == 8'h05 && req8) break;
        end
        tests++;
        if (req8 !== 1'b1 || addr8 !== 8'h01) begin
            fails++; $display("FAIL mid_fetch: req=%b addr=%h want 1 01", req8, addr8);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (req8 !== 1'b0 || acc8 !== 8'h00) begin
            fails++; $display("FAIL async_reset: req=%b acc=%h want 0 00", req8, acc8);
        end
        push_fetches(8'h00, 1);
        @(negedge clock); #1;
        reset = 1'b0;
        drain(50, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL post_reset_fetch: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        bit ok;
        hold_reset();
        load_hlt();
        mem8[0] = 8'hCF; mem8[1] = 8'h24; mem8[2] = 8'hCF; mem8[3] = 8'hDF;
        mem8[255] = 8'hF0;
        waits = 3;
        push_fetches(8'h00, 4);
        push(8'hFF, 1'b0, 8'h00);
        push(8'h00, 1'b0, 8'h00);
        reset = 1'b0;
        drain(300, ok);
        tests++;
        if (!ok || acc8 !== 8'hFF) begin
            fails++; $display("FAIL pc_wrap: left=%0d acc=%h want 0 ff", exp_q.size(), acc8);
        end
    endtask

    initial begin
        fork monitor(); join_none
        #1;
        reset = 1'b1;
        rst16 = 1'b1;
        test_reset();
        test_zero_wait();
        test_mul();
        test_wait_ldst();
        test_branch();
        test_fault_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
